cmd_scheduler: RTL
==================

Name: cmd_scheduler

Overview:
- Time-ordered command queue that feeds the radar pulse-train master (the block with the WR_DATA/REQ_COMMAND interface).
- Buffers host commands. Drops commands whose start time is already too close or in the past.
- Loads exactly one pending command into the master at a time.
- When the master raises REQ_COMMAND because the current command has started executing, loads the next command.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- STALE_MARGIN, 48, minimum lead in 1/48 µs ticks between the current TIME and a command's TIME_START for the command to be accepted for loading.

Ports:
- CLK  in  1  system clock, 48 MHz
- RESET  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  host presents a command
- CMD_READY  out  1  FIFO can accept a command (not full)
- CMD_IN  in  CMD_W  packed cmd_t: dds_freq[48], dds_delta_freq[48], dds_delta_rate[32], time_start[64], n_impuls[16], type_impulse[2], ti[32], tp[32], tblank1[32], tblank2[32]; CMD_W = 338
- FLUSH  in  1  one-cycle pulse: discard all queued commands and cancel the command loaded in the master
- SYS_TIME_UPDATE_OK  in  1  master's system time is synchronised
- TIME  in  64  master system time
- REQ_COMMAND  in  1  master level: high while a command is executing
- WR_DATA  out  1  one-cycle load strobe to the master
- CMD_OUT  out  CMD_W  command presented to the master; valid whenever WR_DATA=1
- FIFO_COUNT  out  $clog2(DEPTH)+1  queued entries
- CMD_DROPPED  out  1  one-cycle pulse per stale command discarded
- DROP_CNT  out  16  saturating count of dropped commands
- ERR_OVF  out  1  sticky: CMD_VALID was high while CMD_READY was low

Behaviour:
- Reset values (RESET=1 at a CLK edge): state=S_IDLE; FIFO empty; WR_DATA=0; CMD_OUT=0; CMD_READY=1; FIFO_COUNT=0; CMD_DROPPED=0; DROP_CNT=0; ERR_OVF=0.
- Push: an entry is written when CMD_VALID && CMD_READY. CMD_READY = (FIFO_COUNT != DEPTH).
- Push and pop in the same cycle are allowed. When full, CMD_READY=0 even if a pop occurs that cycle.
- Overflow: CMD_VALID && !CMD_READY sets ERR_OVF. The offered command is discarded. ERR_OVF clears only on RESET.
- Stale test: the head is stale when {1'b0,head.time_start} <= {1'b0,TIME} + STALE_MARGIN, evaluated in 65-bit arithmetic with no wrap.
- State machine:
  - S_IDLE: no command loaded in the master. If SYS_TIME_UPDATE_OK=1, go to S_CHECK.
  - S_CHECK: if FIFO empty, stay. If head stale, pop it, pulse CMD_DROPPED, increment DROP_CNT (saturate at 0xFFFF), stay. Otherwise register CMD_OUT<=head, pop, go to S_WRITE.
  - S_WRITE: WR_DATA=1 for exactly this cycle; go to S_ARMED.
  - S_ARMED: wait for a rising edge of REQ_COMMAND (registered copy 0, current 1), then go to S_CHECK. Only one command is ever loaded ahead of execution.
- Latency: push at edge N into an empty FIFO, with state=S_CHECK → CMD_OUT valid and WR_DATA=1 in cycle N+2.
- Loss of sync: SYS_TIME_UPDATE_OK=0 in any state → next state S_IDLE. FIFO is kept. A WR_DATA strobe in progress (S_WRITE) still completes.
- FLUSH:
  - FIFO is emptied at the next edge. A simultaneous push is dropped and does not set ERR_OVF.
  - If state was S_ARMED or S_WRITE: one cancel strobe is issued with CMD_OUT=0 except time_start=64'hFFFF_FFFF_FFFF_FFFF, then state goes to S_IDLE.
  - Otherwise the next state is S_IDLE.
- REQ_COMMAND edges outside S_ARMED are ignored.
- The FIFO is strictly in order; the scheduler never reorders by time_start.

Decomposition:
- Package master_pkg:
  - cmd_t packed struct (field order as listed in Ports, dds_freq MSB)
  - CMD_W
  - CANCEL_TIME = all-ones
  - state enum {S_IDLE, S_CHECK, S_WRITE, S_ARMED}
- Sub-module cmd_fifo: synchronous FIFO, parameterised DEPTH and width; register array; first-word-fall-through head output; count output.
- cmd_scheduler contains the FSM, stale compare, drop counter and overflow flag.

Test Plan:
- Reset, SYS_TIME_UPDATE_OK=1, TIME=1000, push cmd time_start=5000 → WR_DATA pulse 2 cycles after the push, CMD_OUT.time_start=5000, FIFO_COUNT returns to 0.
- Push A(5000), B(9000), C(12000) → only A is written. Drive REQ_COMMAND 0→1 → B written 2 cycles later. Hold REQ_COMMAND high → no further WR_DATA until the next rising edge.
- TIME=4990, queue head time_start=5000 (STALE_MARGIN=48) → CMD_DROPPED pulse, DROP_CNT=1, no WR_DATA. Next entry 9000 is written the following cycles.
- Push 9 commands with DEPTH=8 and state held in S_IDLE (SYS_TIME_UPDATE_OK=0) → CMD_READY=0 after 8 pushes, ERR_OVF=1, FIFO_COUNT=8.
- In S_ARMED with 3 queued, pulse FLUSH → FIFO_COUNT=0, one WR_DATA with time_start=64'hFFFF_FFFF_FFFF_FFFF, state S_IDLE.
- Drop SYS_TIME_UPDATE_OK mid-S_CHECK → no WR_DATA, FIFO preserved. Restore it → loading resumes from the same head.

Source files
------------

// File: rtl/master_pkg.sv
// rtl/master_pkg.sv - shared command record, state encoding and cancel pattern for the pulse-train master path
package master_pkg;

  localparam int CMD_W = 338;
  localparam logic [63:0] CANCEL_TIME = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [47:0] dds_freq;
    logic [47:0] dds_delta_freq;
    logic [31:0] dds_delta_rate;
    logic [63:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_impulse;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_ARMED} state_t;

  // A command that can never start: the master treats it as a cancel of the loaded one.
  function automatic cmd_t cancel_cmd();
    cmd_t c;
    c = '0;
    c.time_start = CANCEL_TIME;
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - in-order register-array FIFO with fall-through head and occupancy count
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 338,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// rtl/cmd_scheduler.sv - time-ordered command queue loading one command at a time into the pulse-train master
module cmd_scheduler
  import master_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALE_MARGIN = 48,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [CMD_W-1:0] CMD_IN,
  input  logic             FLUSH,
  input  logic             SYS_TIME_UPDATE_OK,
  input  logic [63:0]      TIME,
  input  logic             REQ_COMMAND,
  output logic             WR_DATA,
  output logic [CMD_W-1:0] CMD_OUT,
  output logic [AW:0]      FIFO_COUNT,
  output logic             CMD_DROPPED,
  output logic [15:0]      DROP_CNT,
  output logic             ERR_OVF
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_t      state;
  cmd_t        head;
  logic [64:0] time_limit;
  logic        push;
  logic        pop;
  logic        empty;
  logic        stale;
  logic        req_q;

  assign CMD_READY  = (FIFO_COUNT != FULL_CNT);
  assign empty      = (FIFO_COUNT == '0);
  assign push       = CMD_VALID && CMD_READY && !FLUSH;
  // 65-bit compare so a TIME near the top of the range never wraps past time_start.
  assign time_limit = {1'b0, TIME} + 65'(STALE_MARGIN);
  assign stale      = ({1'b0, head.time_start} <= time_limit);
  assign pop        = (state == S_CHECK) && SYS_TIME_UPDATE_OK && !FLUSH && !empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (FLUSH),
    .push  (push),
    .pop   (pop),
    .din   (CMD_IN),
    .head  (head),
    .count (FIFO_COUNT)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      WR_DATA     <= 1'b0;
      CMD_OUT     <= '0;
      CMD_DROPPED <= 1'b0;
      DROP_CNT    <= '0;
      ERR_OVF     <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      WR_DATA     <= 1'b0;
      CMD_DROPPED <= 1'b0;
      req_q       <= REQ_COMMAND;
      if (CMD_VALID && !CMD_READY) begin
        ERR_OVF <= 1'b1;
      end
      if (FLUSH) begin
        state <= S_IDLE;
        if (state == S_ARMED || state == S_WRITE) begin
          WR_DATA <= 1'b1;
          CMD_OUT <= cancel_cmd();
        end
      end else if (!SYS_TIME_UPDATE_OK) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE:  state <= S_CHECK;
          S_CHECK: begin
            if (!empty) begin
              if (stale) begin
                CMD_DROPPED <= 1'b1;
                if (DROP_CNT != 16'hFFFF) begin
                  DROP_CNT <= DROP_CNT + 16'd1;
                end
              end else begin
                CMD_OUT <= head;
                WR_DATA <= 1'b1;
                state   <= S_WRITE;
              end
            end
          end
          S_WRITE: state <= S_ARMED;
          S_ARMED: begin
            if (REQ_COMMAND && !req_q) begin
              state <= S_CHECK;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
